// File: rtl/jesd_link_seq.sv
// JESD204B receive-link bring-up/supervision sequencer: RST -> CDR -> CGS -> ILAS -> DATA with bounded retries.
// Define JESD_SYSREF_RESYNC_EN to make sysref_error in DATA force a resynchronisation.
module jesd_link_seq #(
  parameter int LANES      = 8,
  parameter int RST_CYC    = 16,
  parameter int CDR_STABLE = 255,
  parameter int TIMEOUT    = 65535,
  parameter int ERR_THRESH = 4,
  parameter int ERR_WIN_MF = 16,
  parameter int MAX_RETRY  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_cnt,
  input  logic             lmfc_edge,
  input  logic             sysref_error,
  input  logic [LANES-1:0] syncstatus,
  input  logic [LANES-1:0] cgs_ok,
  input  logic [LANES-1:0] lane_ok,
  input  logic [LANES-1:0] errdetect,
  input  logic [LANES-1:0] disperr,
  output logic             sync_n,
  output logic             align_rst,
  output logic             fifo_rst,
  output logic             link_up,
  output logic             fail,
  output logic [2:0]       state,
  output logic [2:0]       retry_cnt,
  output logic [15:0]      err_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    CDR   = 3'd2,
    CGS   = 3'd3,
    ILAS  = 3'd4,
    DATA  = 3'd5,
    RETRY = 3'd6,
    FAIL  = 3'd7
  } state_t;

  localparam int TMAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(CDR_STABLE + 1);
  localparam int MW   = $clog2(ERR_WIN_MF + 1);
  localparam int WW   = $clog2(ERR_THRESH + 1);

  state_t        cur, nxt;
  logic [TW-1:0] tmo, tmo_inc;
  logic [SW-1:0] stab, stab_next;
  logic [MW-1:0] mf_cnt;
  logic [WW-1:0] win_err, win_next;
  logic          win_end, errored, all_sync, sysref_fault;

  assign state = cur;

  always_comb begin
    tmo_inc   = tmo + 1'b1;
    errored   = |(errdetect | disperr);
    all_sync  = &syncstatus;
    stab_next = all_sync ? stab + 1'b1 : '0;
    win_end   = lmfc_edge && (mf_cnt == MW'(ERR_WIN_MF - 1));
    // An error on the window-closing clock belongs to the window that opens.
    win_next  = (win_end ? '0 : win_err) + WW'(errored);
`ifdef JESD_SYSREF_RESYNC_EN
    sysref_fault = sysref_error;
`else
    sysref_fault = 1'b0;
`endif
    nxt = cur;
    if (!enable) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE:  nxt = RST;
        RST:   if (tmo_inc == TW'(RST_CYC)) nxt = CDR;
        CDR: begin
          if (stab_next == SW'(CDR_STABLE)) nxt = CGS;
          else if (tmo_inc == TW'(TIMEOUT)) nxt = RETRY;
        end
        CGS: begin
          if (lmfc_edge && (&cgs_ok)) nxt = ILAS;
          else if (tmo_inc == TW'(TIMEOUT)) nxt = RETRY;
        end
        ILAS: begin
          if (!all_sync) nxt = RETRY;
          else if (&lane_ok) nxt = DATA;
          else if (tmo_inc == TW'(TIMEOUT)) nxt = RETRY;
        end
        DATA: begin
          if (!all_sync || !(&lane_ok) || (win_next >= WW'(ERR_THRESH)) || sysref_fault)
            nxt = RETRY;
        end
        RETRY: nxt = (retry_cnt == 3'(MAX_RETRY)) ? FAIL : RST;
        FAIL:  nxt = FAIL;
        default: nxt = IDLE;
      endcase
    end
  end

`ifndef JESD_SYSREF_RESYNC_EN
  logic sysref_unused;
  assign sysref_unused = sysref_error;
`endif

  // Outputs are decoded from the next state so they are valid on the first clock of each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= IDLE;
      tmo       <= '0;
      stab      <= '0;
      mf_cnt    <= '0;
      win_err   <= '0;
      sync_n    <= 1'b0;
      align_rst <= 1'b1;
      fifo_rst  <= 1'b1;
      link_up   <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      cur  <= nxt;
      tmo  <= ((nxt == cur) && (cur inside {RST, CDR, CGS, ILAS})) ? tmo_inc : '0;
      stab <= ((cur == CDR) && (nxt == CDR)) ? stab_next : '0;
      if ((cur == DATA) && (nxt == DATA)) begin
        if (lmfc_edge) mf_cnt <= win_end ? '0 : mf_cnt + 1'b1;
        win_err <= win_next;
      end else begin
        mf_cnt  <= '0;
        win_err <= '0;
      end
      sync_n    <= (nxt == ILAS) || (nxt == DATA);
      align_rst <= nxt inside {IDLE, RST, FAIL};
      fifo_rst  <= (nxt != DATA);
      link_up   <= (nxt == DATA);
      fail      <= (nxt == FAIL);
      if (nxt == IDLE) retry_cnt <= '0;
      else if ((cur == RETRY) && (nxt == RST) && (retry_cnt != 3'h7)) retry_cnt <= retry_cnt + 1'b1;
      if (clr_cnt) err_cnt <= '0;
      else if ((cur == DATA) && errored && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jesd_link_seq.sv
// Directed bench for jesd_link_seq: bring-up, CDR dropout, error windows, retry exhaustion, enable drop, SYSREF, async reset.
module tb_jesd_link_seq;

  localparam int LANES = 8;
  localparam int TMO   = 600;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable, clr_cnt, lmfc_edge, sysref_error;
  logic [LANES-1:0] syncstatus, cgs_ok, lane_ok, errdetect, disperr;
  logic             sync_n, align_rst, fifo_rst, link_up, fail;
  logic [2:0]       state, retry_cnt;
  logic [15:0]      err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic lmfc_auto = 1'b0;
  int   lmfc_div  = 0;

  jesd_link_seq #(.LANES(LANES), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_cnt(clr_cnt),
    .lmfc_edge(lmfc_edge), .sysref_error(sysref_error), .syncstatus(syncstatus),
    .cgs_ok(cgs_ok), .lane_ok(lane_ok), .errdetect(errdetect), .disperr(disperr),
    .sync_n(sync_n), .align_rst(align_rst), .fifo_rst(fifo_rst), .link_up(link_up),
    .fail(fail), .state(state), .retry_cnt(retry_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk); #1;
    if (lmfc_auto) begin
      lmfc_div  = (lmfc_div == 14) ? 0 : lmfc_div + 1;
      lmfc_edge = (lmfc_div == 0);
    end
  endtask

  task automatic goto_data();
    int n;
    enable = 1'b0; errdetect = '0; disperr = '0; sysref_error = 1'b0;
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    enable = 1'b1; syncstatus = '1; cgs_ok = '1; lane_ok = '1; lmfc_auto = 1'b1;
    n = 0;
    while (state !== 3'd5 && n < 3000) begin tick(); n++; end
    lmfc_auto = 1'b0; lmfc_edge = 1'b0;
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL goto_data: state=%0d expected 5", state); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clr_cnt = 1'b0; lmfc_edge = 1'b0; sysref_error = 1'b0;
    syncstatus = '0; cgs_ok = '0; lane_ok = '0; errdetect = '0; disperr = '0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if (sync_n !== 1'b0) begin n_bad++; $display("FAIL reset_sync_n: got %b expected 0", sync_n); end
    n_cmp++; if (align_rst !== 1'b1) begin n_bad++; $display("FAIL reset_align_rst: got %b expected 1", align_rst); end
    n_cmp++; if (fifo_rst !== 1'b1) begin n_bad++; $display("FAIL reset_fifo_rst: got %b expected 1", fifo_rst); end
    n_cmp++; if (link_up !== 1'b0) begin n_bad++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b expected 0", fail); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_hold: got %0d expected 0", state); end
  endtask

  task automatic test_bringup();
    logic [7:0] visited;
    int cyc, rise_cyc;
    logic pend, seen_edge, cgs_seen;
    visited = '0; cyc = 0; rise_cyc = -1; pend = 1'b0; seen_edge = 1'b0; cgs_seen = 1'b0;
    enable = 1'b1; syncstatus = '0; cgs_ok = '1; lane_ok = '0; lmfc_auto = 1'b1; lmfc_div = 0;
    while (state !== 3'd5 && cyc < 3000) begin
      tick(); cyc++;
      if (cyc == 10) syncstatus = '1;
      if (pend) begin
        pend = 1'b0;
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL cgs_to_ilas: got %0d expected 4", state); end
        n_cmp++; if (sync_n !== 1'b1) begin n_bad++; $display("FAIL sync_n_rise: got %b expected 1", sync_n); end
      end
      visited[state] = 1'b1;
      if (state === 3'd3 && !cgs_seen) begin
        cgs_seen = 1'b1;
        n_cmp++; if (sync_n !== 1'b0) begin n_bad++; $display("FAIL cgs_sync_n_low: got %b expected 0", sync_n); end
      end
      if (state === 3'd3 && lmfc_edge && !seen_edge) begin pend = 1'b1; seen_edge = 1'b1; end
      if (sync_n === 1'b1 && rise_cyc < 0) rise_cyc = cyc;
      if (rise_cyc >= 0 && cyc == rise_cyc + 40) lane_ok = '1;
    end
    lmfc_auto = 1'b0; lmfc_edge = 1'b0;
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL bringup_data: got %0d expected 5", state); end
    n_cmp++; if (visited[5:1] !== 5'b11111) begin n_bad++; $display("FAIL bringup_visited: got %b expected 11111", visited[5:1]); end
    n_cmp++; if (link_up !== 1'b1) begin n_bad++; $display("FAIL bringup_link_up: got %b expected 1", link_up); end
    n_cmp++; if (fifo_rst !== 1'b0) begin n_bad++; $display("FAIL bringup_fifo_rst: got %b expected 0", fifo_rst); end
    n_cmp++; if (align_rst !== 1'b0) begin n_bad++; $display("FAIL bringup_align_rst: got %b expected 0", align_rst); end
  endtask

  task automatic test_cdr_dropout();
    int n;
    enable = 1'b0; tick();
    enable = 1'b1; syncstatus = '1; cgs_ok = '0; lane_ok = '0; lmfc_auto = 1'b0; lmfc_edge = 1'b0;
    n = 0;
    while (state !== 3'd2 && n < 100) begin tick(); n++; end
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL cdr_enter: got %0d expected 2", state); end
    repeat (200) tick();
    syncstatus = 8'hF7;
    tick();
    syncstatus = '1;
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL cdr_dropout_hold: got %0d expected 2", state); end
    repeat (254) tick();
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL cdr_254_after: got %0d expected 2", state); end
    tick();
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL cdr_255_after: got %0d expected 3", state); end
  endtask

  task automatic test_err_window();
    logic [2:0] exp_st;
    goto_data();
    for (int i = 0; i < 4; i++) begin
      errdetect = '0; errdetect[i] = 1'b1;
      tick();
      errdetect = '0;
      exp_st = (i == 3) ? 3'd6 : 3'd5;
      n_cmp++; if (state !== exp_st) begin n_bad++; $display("FAIL err_burst_%0d: got %0d expected %0d", i, state, exp_st); end
      if (i < 3) tick();
    end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL retry_to_rst: got %0d expected 1", state); end
    n_cmp++; if (retry_cnt !== 3'd1) begin n_bad++; $display("FAIL retry_cnt_one: got %0d expected 1", retry_cnt); end
    n_cmp++; if (err_cnt !== 16'd4) begin n_bad++; $display("FAIL err_cnt_four: got %0d expected 4", err_cnt); end

    goto_data();
    for (int i = 0; i < 3; i++) begin
      disperr = '0; disperr[i+1] = 1'b1; tick(); disperr = '0; tick();
    end
    for (int i = 0; i < 15; i++) begin
      lmfc_edge = 1'b1; tick(); lmfc_edge = 1'b0; tick();
    end
    lmfc_edge = 1'b1; errdetect = '0; errdetect[5] = 1'b1;
    tick();
    lmfc_edge = 1'b0; errdetect = '0;
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL win_boundary_err: got %0d expected 5", state); end
    tick();
    for (int i = 0; i < 2; i++) begin
      errdetect = '0; errdetect[7] = 1'b1; tick(); errdetect = '0; tick();
    end
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL win_split_stays: got %0d expected 5", state); end
    errdetect = '0; errdetect[0] = 1'b1; tick(); errdetect = '0;
    n_cmp++; if (state !== 3'd6) begin n_bad++; $display("FAIL new_window_thresh: got %0d expected 6", state); end
    n_cmp++; if (err_cnt !== 16'd7) begin n_bad++; $display("FAIL err_cnt_seven: got %0d expected 7", err_cnt); end
  endtask

  task automatic test_timeout_fail();
    int n, retries, cgs_cyc;
    enable = 1'b0; tick();
    enable = 1'b1; syncstatus = '1; cgs_ok = 8'h7F; lane_ok = '1; lmfc_auto = 1'b1;
    n = 0; retries = 0; cgs_cyc = 0;
    while (state !== 3'd7 && n < 20000) begin
      tick(); n++;
      if (state === 3'd6) retries++;
      if (state === 3'd3 && retries == 0) cgs_cyc++;
    end
    lmfc_auto = 1'b0; lmfc_edge = 1'b0;
    n_cmp++; if (cgs_cyc != TMO) begin n_bad++; $display("FAIL cgs_timeout_len: got %0d expected %0d", cgs_cyc, TMO); end
    n_cmp++; if (retries != 8) begin n_bad++; $display("FAIL retry_count: got %0d expected 8", retries); end
    n_cmp++; if (state !== 3'd7) begin n_bad++; $display("FAIL fail_state: got %0d expected 7", state); end
    n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL fail_flag: got %b expected 1", fail); end
    n_cmp++; if (retry_cnt !== 3'd7) begin n_bad++; $display("FAIL fail_retry_cnt: got %0d expected 7", retry_cnt); end
    n_cmp++; if (align_rst !== 1'b1) begin n_bad++; $display("FAIL fail_align_rst: got %b expected 1", align_rst); end
    repeat (3) tick();
    n_cmp++; if (state !== 3'd7) begin n_bad++; $display("FAIL fail_sticky: got %0d expected 7", state); end
    enable = 1'b0; tick();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL fail_exit_idle: got %0d expected 0", state); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL fail_cleared: got %b expected 0", fail); end
    n_cmp++; if (retry_cnt !== 3'd0) begin n_bad++; $display("FAIL idle_retry_cnt: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_enable_drop();
    goto_data();
    errdetect = '0; errdetect[2] = 1'b1; enable = 1'b0;
    tick();
    errdetect = '0;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL drop_idle: got %0d expected 0", state); end
    n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL drop_err_cnt: got %0d expected 1", err_cnt); end
    n_cmp++; if (link_up !== 1'b0) begin n_bad++; $display("FAIL drop_link_up: got %b expected 0", link_up); end
    n_cmp++; if (fifo_rst !== 1'b1) begin n_bad++; $display("FAIL drop_fifo_rst: got %b expected 1", fifo_rst); end
    tick();
    n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL idle_keeps_err: got %0d expected 1", err_cnt); end
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
    goto_data();
    errdetect = '0; errdetect[0] = 1'b1; clr_cnt = 1'b1;
    tick();
    errdetect = '0; clr_cnt = 1'b0;
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_wins: got %0d expected 0", err_cnt); end
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL clr_stays_data: got %0d expected 5", state); end
  endtask

  task automatic test_sysref();
    logic [2:0] exp1, exp2;
`ifdef JESD_SYSREF_RESYNC_EN
    exp1 = 3'd6; exp2 = 3'd1;
`else
    exp1 = 3'd5; exp2 = 3'd5;
`endif
    goto_data();
    sysref_error = 1'b1; tick(); sysref_error = 1'b0;
    n_cmp++; if (state !== exp1) begin n_bad++; $display("FAIL sysref_state: got %0d expected %0d", state, exp1); end
    tick();
    n_cmp++; if (state !== exp2) begin n_bad++; $display("FAIL sysref_after: got %0d expected %0d", state, exp2); end
  endtask

  task automatic test_async_reset();
    goto_data();
    errdetect = '0; errdetect[4] = 1'b1; tick(); errdetect = '0;
    n_cmp++; if (err_cnt !== 16'd1) begin n_bad++; $display("FAIL pre_reset_err: got %0d expected 1", err_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL arst_state: got %0d expected 0", state); end
    n_cmp++; if (link_up !== 1'b0) begin n_bad++; $display("FAIL arst_link_up: got %b expected 0", link_up); end
    n_cmp++; if (fifo_rst !== 1'b1) begin n_bad++; $display("FAIL arst_fifo_rst: got %b expected 1", fifo_rst); end
    n_cmp++; if (sync_n !== 1'b0) begin n_bad++; $display("FAIL arst_sync_n: got %b expected 0", sync_n); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL arst_err_cnt: got %0d expected 0", err_cnt); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_cdr_dropout();
    test_err_window();
    test_timeout_fail();
    test_enable_drop();
    test_sysref();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
